soc_reset_ctrl: RTL



---
 rtl/soc_rst_pkg.sv | 21 ++
 rtl/rst_sync.sv | 27 ++
 rtl/soc_reset_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/soc_rst_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package soc_rst_pkg;

    // Sequencer states: pad reset held, stretch, peripherals released, all released.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        PERIPH  = 2'd2,
        RUN     = 2'd3
    } rst_state_t;

    // Reset cause encoding reported to firmware.
    localparam logic [1:0] RST_CAUSE_PIN = 2'd0;
    localparam logic [1:0] RST_CAUSE_SW  = 2'd1;
    localparam logic [1:0] RST_CAUSE_WDT = 2'd2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    if (STAGES < 2) begin : g_bad_stages
        $error("rst_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    // Shift ones in after release; pad reset clears the whole chain at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[STAGES-1];

endmodule

// File: rtl/soc_reset_ctrl.sv
// Staged SoC reset sequencer: sync release, stretch, peripherals, then core.
module soc_reset_ctrl
    import soc_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 64,
    parameter int unsigned CORE_DELAY     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sw_rst_req,
    input  logic       i_wdt_rst,
    output logic       o_periph_rst_n,
    output logic       o_core_rst_n,
    output logic [1:0] o_rst_cause,
    output logic       o_rst_busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("soc_reset_ctrl: SYNC_STAGES must be at least 2");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("soc_reset_ctrl: STRETCH_CYCLES must be at least 1");
    end
    if (CORE_DELAY < 1) begin : g_bad_core
        $error("soc_reset_ctrl: CORE_DELAY must be at least 1");
    end

    // Counter only ever reaches max-1, so clog2(max) bits suffice; keep at least one bit.
    localparam int unsigned CNT_MAX = max_u(STRETCH_CYCLES, CORE_DELAY);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST    = CNT_W'(CORE_DELAY - 1);

    logic             sync_rst_n;
    rst_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             periph_q, core_q, busy_q;
    logic             soft_req;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .rst_no (sync_rst_n)
    );

    assign soft_req = i_sw_rst_req | i_wdt_rst;

    // Next-state: sequence progression and soft-reset restart from PERIPH/RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            HOLD: begin
                if (sync_rst_n) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH: begin
                // Requests are deliberately ignored while already in reset.
                if (cnt_q == STRETCH_LAST) begin
                    state_d = PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PERIPH, RUN: begin
                if (soft_req) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                    // Watchdog takes priority when both fire together.
                    cause_d = i_wdt_rst ? RST_CAUSE_WDT : RST_CAUSE_SW;
                end else if (state_q == PERIPH) begin
                    if (cnt_q == CORE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output flops; outputs decode next-state so they change on the deciding edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            cause_q  <= RST_CAUSE_PIN;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= (state_d == PERIPH) || (state_d == RUN);
            core_q   <= (state_d == RUN);
            busy_q   <= (state_d != RUN);
        end
    end

    assign o_periph_rst_n = periph_q;
    assign o_core_rst_n   = core_q;
    assign o_rst_cause    = cause_q;
    assign o_rst_busy     = busy_q;

endmodule
